// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: the D and F requester ports plus the external memory port.
// The master modport is the arbiter's view; the slave modport is the requesters' and the memory's view.
interface mem_arbiter_if;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_write;
    logic        d_size;
    logic [1:0]  d_prot;
    logic        d_seq;
    logic        d_done;
    logic        d_abort;

    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_wdata;
    logic        f_write;
    logic        f_size;
    logic [1:0]  f_prot;
    logic        f_seq;
    logic        f_done;
    logic        f_abort;

    logic [31:0] rdata_o;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        size;
    logic [1:0]  prot;
    logic [1:0]  trans;
    logic [31:0] rdata;
    logic        data_valid;
    logic        abort;

    modport master (
        input  d_req, d_addr, d_wdata, d_write, d_size, d_prot, d_seq,
        output d_done, d_abort,
        input  f_req, f_addr, f_wdata, f_write, f_size, f_prot, f_seq,
        output f_done, f_abort,
        output rdata_o,
        output addr, wdata, write, size, prot, trans,
        input  rdata, data_valid, abort
    );

    modport slave (
        output d_req, d_addr, d_wdata, d_write, d_size, d_prot, d_seq,
        input  d_done, d_abort,
        output f_req, f_addr, f_wdata, f_write, f_size, f_prot, f_seq,
        input  f_done, f_abort,
        input  rdata_o,
        input  addr, wdata, write, size, prot, trans,
        output rdata, data_valid, abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the data path (D) and instruction fetch (F).
// D has fixed priority; a streak limit prevents F starvation, and a response timer bounds each transfer.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_D,
        OWN_F
    } owner_t;

    state_t               r_state;
    owner_t               r_owner;
    owner_t               r_lastOwner;
    logic [STREAK_W-1:0]  r_streak;
    logic                 r_fAtGrant;
    logic [TIMER_W-1:0]   r_timer;

    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_write;
    logic                 r_size;
    logic [1:0]           r_prot;
    logic [1:0]           r_trans;
    logic [31:0]          r_rdata;
    logic                 r_dDone;
    logic                 r_dAbort;
    logic                 r_fDone;
    logic                 r_fAbort;

    logic                 w_grantF;
    logic                 w_grantD;
    owner_t               w_newOwner;
    logic                 w_newSeq;
    logic                 w_timeout;
    logic                 w_response;
    logic                 w_abortFlag;
    logic                 w_ownerD;
    logic                 w_ownerF;

    // F wins only when D is absent or D has used up its streak allowance.
    assign w_grantF    = bus.f_req && (!bus.d_req || (r_streak == STREAK_W'(MAX_D_STREAK)));
    assign w_grantD    = bus.d_req && !w_grantF;
    assign w_newOwner  = w_grantF ? OWN_F : OWN_D;
    assign w_newSeq    = w_grantF ? bus.f_seq : bus.d_seq;
    assign w_timeout   = (r_timer == TIMER_W'(TIMEOUT - 1));
    assign w_response  = bus.data_valid || bus.abort;
    // A timeout (no data_valid) and an explicit abort both complete as aborted.
    assign w_abortFlag = bus.abort || !bus.data_valid;
    assign w_ownerD    = (r_owner == OWN_D);
    assign w_ownerF    = (r_owner == OWN_F);

    assign bus.addr    = r_addr;
    assign bus.wdata   = r_wdata;
    assign bus.write   = r_write;
    assign bus.size    = r_size;
    assign bus.prot    = r_prot;
    assign bus.trans   = r_trans;
    assign bus.rdata_o = r_rdata;
    assign bus.d_done  = r_dDone;
    assign bus.d_abort = r_dAbort;
    assign bus.f_done  = r_fDone;
    assign bus.f_abort = r_fAbort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_NONE;
            r_lastOwner <= OWN_NONE;
            r_streak    <= '0;
            r_fAtGrant  <= 1'b0;
            r_timer     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_size      <= 1'b0;
            r_prot      <= '0;
            r_trans     <= 2'b00;
            r_rdata     <= '0;
            r_dDone     <= 1'b0;
            r_dAbort    <= 1'b0;
            r_fDone     <= 1'b0;
            r_fAbort    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantF || w_grantD) begin
                        r_owner    <= w_newOwner;
                        r_fAtGrant <= bus.f_req;
                        r_addr     <= w_grantF ? bus.f_addr  : bus.d_addr;
                        r_wdata    <= w_grantF ? bus.f_wdata : bus.d_wdata;
                        r_write    <= w_grantF ? bus.f_write : bus.d_write;
                        r_size     <= w_grantF ? bus.f_size  : bus.d_size;
                        r_prot     <= w_grantF ? bus.f_prot  : bus.d_prot;
                        // Sequential only when the same requester continues its own stream.
                        r_trans    <= (w_newSeq && (w_newOwner == r_lastOwner)) ? 2'b11 : 2'b10;
                        r_state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_trans <= 2'b00;
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_response || w_timeout) begin
                        if (w_response && !r_write) begin
                            r_rdata <= bus.rdata;
                        end
                        r_dDone  <= w_ownerD;
                        r_dAbort <= w_ownerD && w_abortFlag;
                        r_fDone  <= w_ownerF;
                        r_fAbort <= w_ownerF && w_abortFlag;
                        r_state  <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_DONE: begin
                    r_dDone     <= 1'b0;
                    r_dAbort    <= 1'b0;
                    r_fDone     <= 1'b0;
                    r_fAbort    <= 1'b0;
                    r_lastOwner <= r_owner;
                    // The streak only grows while F was actually waiting behind D.
                    if (w_ownerD && r_fAtGrant) begin
                        if (r_streak != STREAK_W'(MAX_D_STREAK)) begin
                            r_streak <= r_streak + STREAK_W'(1);
                        end
                    end else begin
                        r_streak <= '0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transfers plus hand-written
// sequences for contention, streak limiting, sequential hints, timeout and reset.
module tb_mem_arbiter;
    localparam int MAX_D_STREAK = 2;
    localparam int TIMEOUT      = 16;

    typedef struct {
        bit        isF;
        bit        write;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        size;
        bit [1:0]  prot;
        bit        seq;
        bit        preload;
        bit [31:0] memWord;
        bit        bothResp;
        bit [1:0]  expTrans;
        bit [31:0] expRdata;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if bus();

    mem_arbiter #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: bench preloads live in memInit, DUT writes land in memWr.
    bit [7:0]  memInit [0:4095];
    bit [7:0]  memWr [0:4095];
    bit        memWrValid [0:4095];
    bit        pending;
    bit        noResponse;
    bit        bothResp;
    bit        memDv;
    bit        memAbort;
    bit        injectDv;
    bit [31:0] memRdata;

    function automatic bit [7:0] memByte(input int a);
        return memWrValid[a] ? memWr[a] : memInit[a];
    endfunction

    function automatic bit [31:0] memWordAt(input int a);
        return {memByte(a + 3), memByte(a + 2), memByte(a + 1), memByte(a)};
    endfunction

    // One-cycle memory: sees trans in ADDR, answers in the first WAIT cycle.
    always @(negedge clk) begin
        int base;
        memDv    = 1'b0;
        memAbort = 1'b0;
        if (pending) begin
            memDv    = 1'b1;
            memAbort = bothResp;
            pending  = 1'b0;
        end
        if (bus.trans != 2'b00 && !noResponse) begin
            base = int'({bus.addr[11:2], 2'b00});
            if (bus.write) begin
                for (int b = 0; b < 4; b++) begin
                    memWr[base + b]      = bus.wdata[8*b +: 8];
                    memWrValid[base + b] = 1'b1;
                end
            end
            memRdata = memWordAt(base);
            pending  = 1'b1;
        end
    end

    assign bus.data_valid = memDv | injectDv;
    assign bus.abort      = memAbort;
    assign bus.rdata      = injectDv ? 32'hBAD0_BAD0 : memRdata;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t makeVec(input bit isF, input bit wr, input bit [31:0] addr,
                                     input bit [31:0] wdata, input bit sz, input bit [1:0] pr,
                                     input bit sq, input bit pre, input bit [31:0] word,
                                     input bit both, input bit [1:0] eTrans, input bit [31:0] eRdata);
        vec_t v;
        v.isF = isF; v.write = wr; v.addr = addr; v.wdata = wdata;
        v.size = sz; v.prot = pr; v.seq = sq; v.preload = pre;
        v.memWord = word; v.bothResp = both; v.expTrans = eTrans; v.expRdata = eRdata;
        return v;
    endfunction

    task automatic driveD(input bit [31:0] addr, input bit [31:0] wdata, input bit wr,
                          input bit sz, input bit [1:0] pr, input bit sq);
        bus.d_addr = addr; bus.d_wdata = wdata; bus.d_write = wr;
        bus.d_size = sz; bus.d_prot = pr; bus.d_seq = sq; bus.d_req = 1'b1;
    endtask

    task automatic driveF(input bit [31:0] addr, input bit [31:0] wdata, input bit wr,
                          input bit sz, input bit [1:0] pr, input bit sq);
        bus.f_addr = addr; bus.f_wdata = wdata; bus.f_write = wr;
        bus.f_size = sz; bus.f_prot = pr; bus.f_seq = sq; bus.f_req = 1'b1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " trans"}, 32'(bus.trans), 32'd0);
        checkOutput({tag, " done/abort"}, 32'({bus.d_done, bus.d_abort, bus.f_done, bus.f_abort}), 32'd0);
        checkOutput({tag, " addr"}, bus.addr, 32'd0);
        checkOutput({tag, " rdata_o"}, bus.rdata_o, 32'd0);
    endtask

    // Called just after a negedge with the DUT in IDLE; returns at the next IDLE cycle.
    task automatic applyStimulus(input vec_t v);
        int base;
        base = int'({v.addr[11:2], 2'b00});
        if (v.preload) begin
            for (int b = 0; b < 4; b++) memInit[base + b] = v.memWord[8*b +: 8];
        end
        bothResp   = v.bothResp;
        noResponse = 1'b0;
        if (v.isF) driveF(v.addr, v.wdata, v.write, v.size, v.prot, v.seq);
        else       driveD(v.addr, v.wdata, v.write, v.size, v.prot, v.seq);
        tick(1);
        checkOutput("trans", 32'(bus.trans), 32'(v.expTrans));
        checkOutput("addr", bus.addr, v.addr);
        checkOutput("write/size/prot", 32'({bus.write, bus.size, bus.prot}), 32'({v.write, v.size, v.prot}));
        if (v.write) checkOutput("wdata", bus.wdata, v.wdata);
        tick(1);
        checkOutput("done early", 32'({bus.d_done, bus.f_done}), 32'd0);
        tick(1);
        checkOutput("done", 32'({bus.d_done, bus.f_done}), v.isF ? 32'd1 : 32'd2);
        checkOutput("abort", 32'({bus.d_abort, bus.f_abort}), v.bothResp ? (v.isF ? 32'd1 : 32'd2) : 32'd0);
        checkOutput("rdata_o", bus.rdata_o, v.expRdata);
        bus.d_req = 1'b0;
        bus.f_req = 1'b0;
        tick(1);
        checkOutput("done clear", 32'({bus.d_done, bus.f_done}), 32'd0);
    endtask

    initial begin
        vec_t vecs [8];
        bit   grantF [$];
        bit   expOrder [6];
        bit   earlyDone;
        bit   quiet;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_write = 1'b0;
        bus.d_size = 1'b0; bus.d_prot = '0; bus.d_seq = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = '0; bus.f_wdata = '0; bus.f_write = 1'b0;
        bus.f_size = 1'b0; bus.f_prot = '0; bus.f_seq = 1'b0;
        injectDv = 1'b0;

        //                isF   wr    addr          wdata          sz    prot   seq   pre   memWord        both  trans  rdata_o
        vecs[0] = makeVec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          1'b1, 2'b10, 1'b0, 1'b1, 32'hE3A0_0001, 1'b0, 2'b10, 32'hE3A0_0001);
        vecs[1] = makeVec(1'b1, 1'b0, 32'h0000_0014, 32'h0,          1'b1, 2'b10, 1'b1, 1'b1, 32'hE1A0_F00E, 1'b0, 2'b11, 32'hE1A0_F00E);
        vecs[2] = makeVec(1'b0, 1'b0, 32'h0000_0200, 32'h0,          1'b0, 2'b01, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 2'b10, 32'h1234_5678);
        vecs[3] = makeVec(1'b0, 1'b0, 32'h0000_0204, 32'h0,          1'b0, 2'b01, 1'b1, 1'b1, 32'h9ABC_DEF0, 1'b0, 2'b11, 32'h9ABC_DEF0);
        vecs[4] = makeVec(1'b0, 1'b1, 32'h0000_0208, 32'h55AA_33CC,  1'b1, 2'b11, 1'b0, 1'b0, 32'h0,         1'b0, 2'b10, 32'h9ABC_DEF0);
        vecs[5] = makeVec(1'b1, 1'b1, 32'h0000_0020, 32'h0102_0304,  1'b1, 2'b00, 1'b1, 1'b0, 32'h0,         1'b0, 2'b10, 32'h9ABC_DEF0);
        vecs[6] = makeVec(1'b1, 1'b0, 32'h0000_0020, 32'h0,          1'b1, 2'b10, 1'b1, 1'b0, 32'h0,         1'b0, 2'b11, 32'h0102_0304);
        vecs[7] = makeVec(1'b0, 1'b0, 32'h0000_0030, 32'h0,          1'b0, 2'b01, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 2'b10, 32'h0BAD_F00D);

        // Reset state, checked both while held and just after release.
        tick(3);
        checkIdleOutputs("reset");
        checkOutput("reset wdata/ctrl", 32'({bus.wdata[15:0], bus.write, bus.size, bus.prot}), 32'd0);
        rst = 1'b1;
        tick(1);
        checkIdleOutputs("post-reset");

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        checkOutput("mem 0x208 after D write", memWordAt(32'h208), 32'h55AA_33CC);

        // D and F raised together: D first, then F in the following IDLE.
        bothResp = 1'b0;
        driveD(32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b00, 1'b0);
        driveF(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick(1);
        checkOutput("contend D trans", 32'(bus.trans), 32'd2);
        checkOutput("contend D addr", bus.addr, 32'h100);
        checkOutput("contend D write", 32'(bus.write), 32'd1);
        tick(2);
        checkOutput("contend D done", 32'({bus.d_done, bus.d_abort, bus.f_done, bus.f_abort}), 32'b1000);
        bus.d_req = 1'b0;
        tick(2);
        checkOutput("contend F trans", 32'(bus.trans), 32'd2);
        checkOutput("contend F addr", bus.addr, 32'h10);
        tick(2);
        checkOutput("contend F done", 32'({bus.d_done, bus.d_abort, bus.f_done, bus.f_abort}), 32'b0010);
        checkOutput("contend F rdata_o", bus.rdata_o, 32'hE3A0_0001);
        bus.f_req = 1'b0;
        tick(1);
        checkOutput("mem byte 0x100", 32'(memByte(32'h100)), 32'hEF);
        checkOutput("mem word 0x100", memWordAt(32'h100), 32'hDEAD_BEEF);

        // Both held high with a streak limit of two: D,D,F,D,D,F.
        expOrder = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        driveD(32'h300, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        driveF(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        for (int i = 1; i <= 22; i++) begin
            tick(1);
            if (bus.trans != 2'b00) grantF.push_back(bus.addr == 32'h10);
        end
        tick(1);
        checkOutput("streak last f_done", 32'(bus.f_done), 32'd1);
        bus.d_req = 1'b0;
        bus.f_req = 1'b0;
        tick(1);
        checkOutput("streak grant count", 32'(grantF.size()), 32'd6);
        for (int k = 0; k < 6 && k < grantF.size(); k++) begin
            checkOutput($sformatf("streak grant %0d is F", k), 32'(grantF[k]), 32'(expOrder[k]));
        end

        // Sequential hint: D stream continues, an F grant in between breaks it.
        applyStimulus(makeVec(1'b0, 1'b0, 32'h208, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 32'h55AA_33CC));
        applyStimulus(makeVec(1'b0, 1'b0, 32'h20C, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b11, 32'h0));
        applyStimulus(makeVec(1'b1, 1'b0, 32'h010, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 2'b10, 32'hE3A0_0001));
        applyStimulus(makeVec(1'b0, 1'b0, 32'h204, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 32'h9ABC_DEF0));

        // Silent memory: sixteen WAIT cycles follow the trans cycle, then an aborted DONE.
        noResponse = 1'b1;
        driveD(32'h400, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(1);
        checkOutput("timeout trans", 32'(bus.trans), 32'd2);
        earlyDone = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            tick(1);
            if (bus.d_done || bus.f_done) earlyDone = 1'b1;
        end
        checkOutput("timeout no early done", 32'(earlyDone), 32'd0);
        tick(1);
        checkOutput("timeout done/abort", 32'({bus.d_done, bus.d_abort, bus.f_done, bus.f_abort}), 32'b1100);
        checkOutput("timeout rdata_o", bus.rdata_o, 32'h9ABC_DEF0);
        bus.d_req = 1'b0;
        tick(1);
        injectDv = 1'b1;
        tick(1);
        injectDv = 1'b0;
        checkOutput("late dv trans", 32'(bus.trans), 32'd0);
        tick(1);
        checkOutput("late dv done", 32'({bus.d_done, bus.f_done}), 32'd0);
        checkOutput("late dv rdata_o", bus.rdata_o, 32'h9ABC_DEF0);
        noResponse = 1'b0;

        // Reset dropped in WAIT: everything clears at once, no stray done afterwards.
        noResponse = 1'b1;
        driveF(32'h40, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick(1);
        checkOutput("pre-reset trans", 32'(bus.trans), 32'd2);
        tick(1);
        rst = 1'b0;
        #1;
        checkIdleOutputs("mid reset");
        bus.f_req = 1'b0;
        tick(1);
        rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.d_done || bus.f_done || bus.trans != 2'b00) quiet = 1'b0;
        end
        checkOutput("post-reset quiet", 32'(quiet), 32'd1);
        noResponse = 1'b0;
        applyStimulus(makeVec(1'b1, 1'b0, 32'h010, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 32'hE3A0_0001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
